// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a window of 2**N valid stream bits.
// Latency: result_valid rises on the edge that samples the 2**N-th valid bit.
// Backpressure: result is held in HOLD until result_ready; the stream is not consumed meanwhile.
module sc_stream_decoder #(
    parameter int N       = 6,
    parameter bit BIPOLAR = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         busy,
    output logic [N+1:0] result,
    output logic         result_valid,
    input  logic         result_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [N+1:0] WINDOW   = {2'b01, {N{1'b0}}};
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
    localparam logic [N-1:0] ONE_IDX  = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N:0]   count;
    logic [N-1:0] sample_cnt;
    logic [N:0]   count_next;
    logic [N+1:0] decoded;

    // The final sample is folded in here so the result is ready on the same edge.
    assign count_next = count + {{N{1'b0}}, bit_in};

    always_comb begin
        decoded = {1'b0, count_next};
        if (BIPOLAR) begin
            decoded = {count_next, 1'b0} - WINDOW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            sample_cnt   <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    if (start) begin
                        state      <= ACCUM;
                        count      <= '0;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bit_valid) begin
                        count      <= count_next;
                        sample_cnt <= sample_cnt + ONE_IDX;
                        if (sample_cnt == LAST_IDX) begin
                            result       <= decoded;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state      <= ACCUM;
                            count      <= '0;
                            sample_cnt <= '0;
                            busy       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
